// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester BRAM port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

    // Arbiter FSM: nobody owns the port, or M0 / M1 owns it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Requester identity, also used as the read-return tag.
    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } owner_t;

    // One slot of the read-return pipeline.
    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-tag delay line: carries {valid, owner} of each granted read to its data return.
// Latency: DEPTH cycles from push to pop.
// Backpressure: none; one tag enters and one leaves every cycle.
//
// Ports: clk, reset (async active-low), push (tag entering this cycle),
//        pop (tag aligned with mem_rdata), pending (any valid tag in flight).
module rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t push,
    output rd_tag_t pop,
    output logic    pending
);

    rd_tag_t stage [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= push;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign pop = stage[DEPTH-1];

    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            pending = pending | stage[i].valid;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port BRAM between M0 (CPU) and M1 (loader/debug) with bounded bursts.
// Latency: req->gnt 1 cycle from IDLE, 0 while owning; read data RD_LATENCY cycles after gnt.
// Backpressure: req/gnt handshake; a requester holds its request until it sees gnt.
//
// Ports: clk, reset (async active-low);
//        mN_req/mN_we/mN_addr/mN_wdata in, mN_gnt/mN_rvalid/mN_rdata out (N = 0, 1);
//        mem_addr/mem_we/mem_wdata to the BRAM, mem_rdata from it; busy status.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = cnt_t'(MAX_BURST);

    arb_state_t state, state_nxt;
    cnt_t       burst_cnt, burst_nxt;
    owner_t     last_owner, last_nxt;

    // Per-cycle view of the current owner versus the other requester.
    owner_t     cur_owner;
    arb_state_t oth_state;
    logic       own_req;
    logic       oth_req;
    logic       grant_any;
    cnt_t       cnt_inc;

    rd_tag_t    tag_in;
    rd_tag_t    tag_out;
    logic       rd_pending;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            last_owner <= M1;   // lets M0 win the first tie after reset
        end else begin
            state      <= state_nxt;
            burst_cnt  <= burst_nxt;
            last_owner <= last_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Grants and memory mux: purely a function of the registered owner
    // ------------------------------------------------------------------
    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            OWN0: begin
                m0_gnt    = m0_req;
                mem_addr  = m0_addr;
                mem_we    = m0_req & m0_we;
                mem_wdata = m0_wdata;
            end
            OWN1: begin
                m1_gnt    = m1_req;
                mem_addr  = m1_addr;
                mem_we    = m1_req & m1_we;
                mem_wdata = m1_wdata;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state, burst counter and tie-break memory
    // ------------------------------------------------------------------
    always_comb begin
        cur_owner = (state == OWN1) ? M1 : M0;
        oth_state = (state == OWN1) ? OWN0 : OWN1;
        own_req   = (state == OWN1) ? m1_req : m0_req;
        oth_req   = (state == OWN1) ? m0_req : m1_req;
        grant_any = m0_gnt | m1_gnt;
        // Count includes this cycle's grant so the switch lands right after the last one.
        cnt_inc   = (grant_any && (burst_cnt != CNT_MAX)) ? burst_cnt + cnt_t'(1) : burst_cnt;

        state_nxt = state;
        burst_nxt = burst_cnt;
        last_nxt  = last_owner;

        case (state)
            IDLE: begin
                burst_nxt = '0;
                if (m0_req && m1_req) begin
                    state_nxt = (last_owner == M1) ? OWN0 : OWN1;
                end else if (m0_req) begin
                    state_nxt = OWN0;
                end else if (m1_req) begin
                    state_nxt = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!own_req) begin
                    // Owner went quiet: hand over directly, or park in IDLE.
                    burst_nxt = '0;
                    last_nxt  = cur_owner;
                    state_nxt = oth_req ? oth_state : IDLE;
                end else if ((cnt_inc == CNT_MAX) && oth_req) begin
                    burst_nxt = '0;
                    last_nxt  = cur_owner;
                    state_nxt = oth_state;
                end else begin
                    burst_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                burst_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read return routing: tag follows the read through the BRAM latency
    // ------------------------------------------------------------------
    always_comb begin
        tag_in       = '0;
        tag_in.valid = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
        tag_in.owner = cur_owner;
    end

    rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .push    (tag_in),
        .pop     (tag_out),
        .pending (rd_pending)
    );

    assign m0_rvalid = tag_out.valid && (tag_out.owner == M0);
    assign m1_rvalid = tag_out.valid && (tag_out.owner == M1);
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

    assign busy = (state != IDLE) || rd_pending;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int MB = 4;
    localparam int RL = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_BURST(MB), .RD_LATENCY(RL)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Synchronous-read BRAM, read-before-write, one cycle latency.
    logic [31:0] bmem [0:255];
    always @(posedge clk) begin
        mem_rdata <= bmem[mem_addr[9:2]];
        if (mem_we) bmem[mem_addr[9:2]] = mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic g0, input logic g1,
                            input logic rv0, input logic rv1, input logic bz);
        chk({name, ".m0_gnt"},    {31'b0, m0_gnt},    {31'b0, g0});
        chk({name, ".m1_gnt"},    {31'b0, m1_gnt},    {31'b0, g1});
        chk({name, ".m0_rvalid"}, {31'b0, m0_rvalid}, {31'b0, rv0});
        chk({name, ".m1_rvalid"}, {31'b0, m1_rvalid}, {31'b0, rv1});
        chk({name, ".busy"},      {31'b0, busy},      {31'b0, bz});
    endtask

    // Apply one cycle of requester inputs after the falling edge, then settle.
    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        @(negedge clk);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        #1;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic        r0, r1;
        logic        g0, g1, rv0, rv1, bz;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        int          due;
        int          who;
        logic [31:0] data;
    } ret_t;

    vec_t        tv [15];
    logic [31:0] mmem [0:255];
    ret_t        rq [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) bmem[i] = 32'hA500_0000 | i;
        bmem[4] = 32'hDEADBEEF;

        // ---------------- 1: reset behaviour ----------------
        reset = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        repeat (3) @(negedge clk);
        #1;
        chk_outs("t1_in_reset", 0, 0, 0, 0, 0);
        chk("t1.mem_we",    {31'b0, mem_we}, 32'h0);
        chk("t1.mem_addr",  mem_addr,  32'h0);
        chk("t1.mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        chk_outs("t1_after", 0, 0, 0, 0, 0);

        // ---------------- 2: single M0 read from IDLE ----------------
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        chk_outs("t2_c0", 0, 0, 0, 0, 0);
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        chk_outs("t2_c1", 1, 0, 0, 0, 1);
        chk("t2.mem_addr", mem_addr, 32'h10);
        drive_idle();
        chk_outs("t2_c2", 0, 0, 1, 0, 1);
        chk("t2.m0_rdata", m0_rdata, 32'hDEADBEEF);
        drive_idle();
        chk_outs("t2_c3", 0, 0, 0, 0, 0);

        // ---------------- 3: table, both requesting continuously ----------------
        tv[0]  = '{1, 1, 0, 0, 0, 0, 0, 32'h0};
        tv[1]  = '{1, 1, 1, 0, 0, 0, 1, 32'h0};
        tv[2]  = '{1, 1, 1, 0, 1, 0, 1, 32'hDEADBEEF};
        tv[3]  = '{1, 1, 1, 0, 1, 0, 1, 32'hDEADBEEF};
        tv[4]  = '{1, 1, 1, 0, 1, 0, 1, 32'hDEADBEEF};
        tv[5]  = '{1, 1, 0, 1, 1, 0, 1, 32'hDEADBEEF};
        tv[6]  = '{1, 1, 0, 1, 0, 1, 1, 32'hA500_0005};
        tv[7]  = '{1, 1, 0, 1, 0, 1, 1, 32'hA500_0005};
        tv[8]  = '{1, 1, 0, 1, 0, 1, 1, 32'hA500_0005};
        tv[9]  = '{1, 1, 1, 0, 0, 1, 1, 32'hA500_0005};
        tv[10] = '{1, 1, 1, 0, 1, 0, 1, 32'hDEADBEEF};
        tv[11] = '{1, 1, 1, 0, 1, 0, 1, 32'hDEADBEEF};
        tv[12] = '{1, 1, 1, 0, 1, 0, 1, 32'hDEADBEEF};
        tv[13] = '{0, 0, 0, 0, 1, 0, 1, 32'hDEADBEEF};
        tv[14] = '{0, 0, 0, 0, 0, 0, 0, 32'h0};
        do_reset();
        for (int k = 0; k < 15; k++) begin
            drive(tv[k].r0, 0, 32'h10, 0, tv[k].r1, 0, 32'h14, 0);
            chk_outs($sformatf("t3_row%0d", k), tv[k].g0, tv[k].g1, tv[k].rv0, tv[k].rv1, tv[k].bz);
            if (tv[k].rv0) chk($sformatf("t3_row%0d.m0_rdata", k), m0_rdata, tv[k].rd);
            if (tv[k].rv1) chk($sformatf("t3_row%0d.m1_rdata", k), m1_rdata, tv[k].rd);
        end

        // ---------------- 4: M0 write vs M1 read, same address ----------------
        do_reset();
        drive(1, 1, 32'h20, 32'h12345678, 1, 0, 32'h20, 0);
        chk_outs("t4_c0", 0, 0, 0, 0, 0);
        drive(1, 1, 32'h20, 32'h12345678, 1, 0, 32'h20, 0);
        chk_outs("t4_c1", 1, 0, 0, 0, 1);
        chk("t4.mem_we", {31'b0, mem_we}, 32'h1);
        drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
        chk_outs("t4_c2", 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
        chk_outs("t4_c3", 0, 1, 0, 0, 1);
        drive_idle();
        chk_outs("t4_c4", 0, 0, 0, 1, 1);
        chk("t4.m1_rdata", m1_rdata, 32'h12345678);

        // ---------------- 5: M0 read then M1 read on owner switch ----------------
        do_reset();
        drive(1, 0, 32'h40, 0, 1, 0, 32'h50, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 32'h40 + 32'(4 * k), 0, 1, 0, 32'h50, 0);
            chk($sformatf("t5_burst%0d.m0_gnt", k), {31'b0, m0_gnt}, 32'h1);
        end
        drive(0, 0, 0, 0, 1, 0, 32'h50, 0);
        chk_outs("t5_sw", 0, 1, 1, 0, 1);
        chk("t5.m0_rdata", m0_rdata, 32'hA500_0013);
        drive_idle();
        chk_outs("t5_after", 0, 0, 0, 1, 1);
        chk("t5.m1_rdata", m1_rdata, 32'hA500_0014);

        // ---------------- 6: reset with a read in flight ----------------
        do_reset();
        drive(1, 1, 32'h60, 32'hCAFE0000, 0, 0, 0, 0);
        drive(1, 1, 32'h60, 32'hCAFE0000, 0, 0, 0, 0);
        drive_idle();                         // back to IDLE with M0 as last owner
        drive(1, 0, 32'h60, 0, 0, 0, 0, 0);
        drive(1, 0, 32'h60, 0, 0, 0, 0, 0);
        chk("t6_pre.m0_gnt", {31'b0, m0_gnt}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0;
        #1;
        chk_outs("t6_rst0", 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk_outs("t6_rst1", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        chk_outs("t6_rel", 0, 0, 0, 0, 0);
        drive(1, 0, 32'h60, 0, 1, 0, 32'h64, 0);
        chk_outs("t6_tie0", 0, 0, 0, 0, 0);
        drive(1, 0, 32'h60, 0, 1, 0, 32'h64, 0);
        chk_outs("t6_tie1", 1, 0, 0, 0, 1);

        // ---------------- random traffic against a reference model ----------------
        do_reset();
        for (int i = 0; i < 256; i++) mmem[i] = bmem[i];
        begin
            int          own, cnt, last, cyc, w0, w1, p;
            logic        r0, r1, wv0, wv1, pg0, pg1;
            logic [31:0] a0, a1, d0, d1;
            logic        eg0, eg1, erv0, erv1, ebz;
            logic [31:0] erd;
            own = -1; cnt = 0; last = 1;
            r0 = 0; r1 = 0; wv0 = 0; wv1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
            pg0 = 0; pg1 = 0; w0 = 0; w1 = 0;
            rq.delete();
            for (cyc = 0; cyc < 3000; cyc++) begin
                p = (cyc < 1500) ? 90 : 45;
                // A requester may issue a new access once its current one was granted.
                if (!r0 || pg0) begin
                    r0 = ($urandom_range(0, 99) < p);
                    wv0 = $urandom_range(0, 1) == 1;
                    a0 = 32'h100 + 32'($urandom_range(0, 15) << 2);
                    d0 = $urandom;
                    w0 = 0;
                end
                if (!r1 || pg1) begin
                    r1 = ($urandom_range(0, 99) < p);
                    wv1 = $urandom_range(0, 1) == 1;
                    a1 = 32'h100 + 32'($urandom_range(0, 15) << 2);
                    d1 = $urandom;
                    w1 = 0;
                end
                drive(r0, wv0, a0, d0, r1, wv1, a1, d1);

                eg0  = (own == 0) && r0;
                eg1  = (own == 1) && r1;
                ebz  = (own != -1) || (rq.size() > 0);
                erv0 = 0; erv1 = 0; erd = 0;
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    erv0 = (rq[0].who == 0);
                    erv1 = (rq[0].who == 1);
                    erd  = rq[0].data;
                    void'(rq.pop_front());
                end
                chk_outs($sformatf("rnd%0d", cyc), eg0, eg1, erv0, erv1, ebz);
                if (erv0) chk($sformatf("rnd%0d.m0_rdata", cyc), m0_rdata, erd);
                if (erv1) chk($sformatf("rnd%0d.m1_rdata", cyc), m1_rdata, erd);
                if (eg0 || eg1) begin
                    chk($sformatf("rnd%0d.mem_addr", cyc), mem_addr, eg0 ? a0 : a1);
                    chk($sformatf("rnd%0d.mem_we", cyc), {31'b0, mem_we}, {31'b0, eg0 ? wv0 : wv1});
                end
                if (m0_gnt) chk($sformatf("rnd%0d.m0_wait", cyc), 32'(w0), (w0 <= MB + 1) ? 32'(w0) : 32'(MB + 1));
                if (m1_gnt) chk($sformatf("rnd%0d.m1_wait", cyc), 32'(w1), (w1 <= MB + 1) ? 32'(w1) : 32'(MB + 1));
                if (r0 && !m0_gnt) w0++;
                if (r1 && !m1_gnt) w1++;
                pg0 = m0_gnt;
                pg1 = m1_gnt;

                // Memory side effects of this cycle's access.
                if (eg0 || eg1) begin
                    if (eg0 ? wv0 : wv1) mmem[eg0 ? a0[9:2] : a1[9:2]] = eg0 ? d0 : d1;
                    else rq.push_back('{cyc + RL, eg0 ? 0 : 1, mmem[eg0 ? a0[9:2] : a1[9:2]]});
                end

                // Ownership for the next cycle.
                if (own == -1) begin
                    cnt = 0;
                    if (r0 && r1) own = (last == 0) ? 1 : 0;
                    else if (r0)  own = 0;
                    else if (r1)  own = 1;
                end else begin
                    int  c;
                    logic rm, ro;
                    rm = (own == 0) ? r0 : r1;
                    ro = (own == 0) ? r1 : r0;
                    c  = cnt + ((eg0 || eg1) ? 1 : 0);
                    if (c > MB) c = MB;
                    if (!rm) begin
                        last = own; cnt = 0; own = ro ? 1 - own : -1;
                    end else if (c >= MB && ro) begin
                        last = own; cnt = 0; own = 1 - own;
                    end else begin
                        cnt = c;
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
